// File: rtl/clock_ctrl.sv
// clock_ctrl: mode FSM and carry-chain control for a HH:MM:SS digital clock.
// Build option: SET_TIMEOUT_EN adds a 30-tick inactivity exit from SET modes.
//
// Ports:
//   clk_out     in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   tick_1hz    in   one-cycle pulse per second
//   mode_btn    in   one-cycle pulse, advances RUN->SET_HOUR->SET_MIN->RUN
//   inc_btn     in   one-cycle pulse, increments the selected field
//   over[5:0]   in   digit carries {h1,h0,m1,m0,s1,s0}
//   hour1_value in   tens-of-hours digit
//   inc[5:0]    out  digit increment enables, same order as over
//   re          out  hour0 early rollover (tens-of-hours is 2)
//   clr_sec     out  one-cycle clear of seconds on SET_MIN exit
//   mode[1:0]   out  00 RUN, 01 SET_HOUR, 10 SET_MIN
//   blink       out  blank the selected field while setting

module clock_ctrl (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [5:0] over,
    input  logic [3:0] hour1_value,
    output logic [5:0] inc,
    output logic       re,
    output logic       clr_sec,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t     state_q;
    logic       blink_q;
    logic       clr_q;
    logic [5:0] inc_d;
    logic       in_set;
    logic       tmo_hit;
    logic       set_btn;

    assign in_set  = (state_q == SET_HOUR) || (state_q == SET_MIN);
    // A simultaneous mode press wins over the increment.
    assign set_btn = inc_btn & ~mode_btn;

`ifdef SET_TIMEOUT_EN
    logic [4:0] tmo_q;

    // Hit on the edge where the count would reach 30.
    assign tmo_hit = in_set && tick_1hz && !mode_btn && !inc_btn
                     && (tmo_q == 5'd29);

    always_ff @(posedge clk_out) begin
        if (rst || !in_set || mode_btn || inc_btn || tmo_hit) begin
            tmo_q <= 5'd0;
        end else if (tick_1hz) begin
            tmo_q <= tmo_q + 5'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Same-cycle carry chain; minutes never carry into hours while setting.
    always_comb begin
        inc_d = 6'b0;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    inc_d[0] = tick_1hz;
                    inc_d[1] = inc_d[0] & over[0];
                    inc_d[2] = inc_d[1] & over[1];
                    inc_d[3] = inc_d[2] & over[2];
                    inc_d[4] = inc_d[3] & over[3];
                    inc_d[5] = inc_d[4] & over[4];
                end
                SET_HOUR: begin
                    inc_d[4] = set_btn;
                    inc_d[5] = inc_d[4] & over[4];
                end
                SET_MIN: begin
                    inc_d[2] = set_btn;
                    inc_d[3] = inc_d[2] & over[2];
                end
                default: inc_d = 6'b0;
            endcase
        end
    end

    always_ff @(posedge clk_out) begin
        if (rst) begin
            state_q <= RUN;
            blink_q <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    blink_q <= 1'b0;
                    if (mode_btn) begin
                        state_q <= SET_HOUR;
                        blink_q <= 1'b1;
                    end
                end
                SET_HOUR: begin
                    if (mode_btn) begin
                        state_q <= SET_MIN;
                        blink_q <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q <= RUN;
                        blink_q <= 1'b0;
                    end else if (tick_1hz) begin
                        blink_q <= ~blink_q;
                    end
                end
                SET_MIN: begin
                    if (mode_btn || tmo_hit) begin
                        state_q <= RUN;
                        blink_q <= 1'b0;
                        clr_q   <= 1'b1;
                    end else if (tick_1hz) begin
                        blink_q <= ~blink_q;
                    end
                end
                default: begin
                    state_q <= RUN;
                    blink_q <= 1'b0;
                end
            endcase
        end
    end

    assign inc     = inc_d;
    assign re      = (hour1_value == 4'd2);
    assign clr_sec = clr_q;
    assign mode    = state_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed vectors with a queued scoreboard for clock_ctrl.
// Define SET_TIMEOUT_EN on both files to exercise the timeout path.

module tb_clock_ctrl;

    logic       clk_out = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [5:0] over = 6'b0;
    logic [3:0] hour1_value = 4'd0;
    logic [5:0] inc;
    logic       re;
    logic       clr_sec;
    logic [1:0] mode;
    logic       blink;

    clock_ctrl dut (
        .clk_out     (clk_out),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .mode_btn    (mode_btn),
        .inc_btn     (inc_btn),
        .over        (over),
        .hour1_value (hour1_value),
        .inc         (inc),
        .re          (re),
        .clr_sec     (clr_sec),
        .mode        (mode),
        .blink       (blink)
    );

    always #5 clk_out = ~clk_out;

    typedef struct {
        string      nm;
        bit         cc;
        logic [5:0] ei;
        logic       ere;
        bit         cr;
        logic [1:0] em;
        logic       eb;
        logic       ec;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    bit   pend_v = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input string f,
                         input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, f, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show:
    // combinational outputs this cycle, registered outputs next cycle.
    task automatic step(input string nm, input bit r, input bit t,
                        input bit m, input bit i, input logic [5:0] ov,
                        input logic [3:0] h1, input bit cc,
                        input logic [5:0] ei, input logic ere,
                        input bit cr, input logic [1:0] em,
                        input logic eb, input logic ec);
        exp_t e;
        @(posedge clk_out);
        #1;
        rst = r;
        tick_1hz = t;
        mode_btn = m;
        inc_btn = i;
        over = ov;
        hour1_value = h1;
        e.nm = nm;
        e.cc = cc;
        e.ei = ei;
        e.ere = ere;
        e.cr = cr;
        e.em = em;
        e.eb = eb;
        e.ec = ec;
        q.push_back(e);
    endtask

    // Monitor: outputs are stable mid-cycle, so sample on the falling edge.
    always @(negedge clk_out) begin
        if (pend_v && pend.cr) begin
            check(pend.nm, "mode", {6'b0, mode}, {6'b0, pend.em});
            check(pend.nm, "blink", {7'b0, blink}, {7'b0, pend.eb});
            check(pend.nm, "clr_sec", {7'b0, clr_sec}, {7'b0, pend.ec});
        end
        pend_v = 1'b0;
        if (q.size() > 0) begin
            pend = q.pop_front();
            pend_v = 1'b1;
            if (pend.cc) begin
                check(pend.nm, "inc", {2'b0, inc}, {2'b0, pend.ei});
                check(pend.nm, "re", {7'b0, re}, {7'b0, pend.ere});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset dominates tick and inc_btn.
        step("rst_a", 1, 1, 0, 1, 6'h3f, 4'd2, 1, 6'h00, 1, 1, 2'b00, 0, 0);
        step("rst_b", 1, 0, 0, 0, 6'h00, 4'd0, 1, 6'h00, 0, 1, 2'b00, 0, 0);
        // RUN carry chain.
        step("run_235959", 0, 1, 0, 0, 6'h3f, 4'd2, 1, 6'h3f, 1, 1, 2'b00, 0, 0);
        step("run_part", 0, 1, 0, 0, 6'h01, 4'd1, 1, 6'h03, 0, 1, 2'b00, 0, 0);
        step("run_notick", 0, 0, 0, 0, 6'h3f, 4'd0, 1, 6'h00, 0, 1, 2'b00, 0, 0);
        step("run_incbtn", 0, 0, 0, 1, 6'h3f, 4'd0, 1, 6'h00, 0, 1, 2'b00, 0, 0);
        // Tick with the entering mode press still counts.
        step("enter_tick", 0, 1, 1, 0, 6'h01, 4'd0, 1, 6'h03, 0, 1, 2'b01, 1, 0);
        step("sh_tick", 0, 1, 0, 0, 6'h3f, 4'd0, 1, 6'h00, 0, 1, 2'b01, 0, 0);
        step("sh_inc", 0, 0, 0, 1, 6'h10, 4'd2, 1, 6'h30, 1, 1, 2'b01, 0, 0);
        step("sh_tick2", 0, 1, 0, 0, 6'h00, 4'd0, 1, 6'h00, 0, 1, 2'b01, 1, 0);
        step("sh_both", 0, 0, 1, 1, 6'h3f, 4'd0, 1, 6'h00, 0, 1, 2'b10, 1, 0);
        step("sm_inc59", 0, 0, 0, 1, 6'h3f, 4'd0, 1, 6'h0c, 0, 1, 2'b10, 1, 0);
        step("sm_tick", 0, 1, 0, 0, 6'h3f, 4'd0, 1, 6'h00, 0, 1, 2'b10, 0, 0);
        step("sm_exit", 0, 0, 1, 0, 6'h00, 4'd0, 1, 6'h00, 0, 1, 2'b00, 0, 1);
        step("run_idle", 0, 0, 0, 0, 6'h00, 4'd0, 1, 6'h00, 0, 1, 2'b00, 0, 0);
        // Three back-to-back mode presses.
        step("m3_a", 0, 0, 1, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b01, 1, 0);
        step("m3_b", 0, 0, 1, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b10, 1, 0);
        step("m3_c", 0, 0, 1, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b00, 0, 1);
        step("m3_d", 0, 0, 0, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b00, 0, 0);
        // Reset inside SET_MIN: no clr_sec pulse.
        step("r_a", 0, 0, 1, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b01, 1, 0);
        step("r_b", 0, 0, 1, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b10, 1, 0);
        step("r_sm", 1, 1, 0, 1, 6'h3f, 4'd2, 1, 6'h00, 1, 1, 2'b00, 0, 0);
        step("r_after", 0, 0, 0, 0, 6'h00, 4'd0, 1, 6'h00, 0, 1, 2'b00, 0, 0);
        // Idle ticks in SET_HOUR, restarted by inc_btn after 29 ticks.
        step("to_enter", 0, 0, 1, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b01, 1, 0);
        for (int k = 1; k <= 29; k++)
            step("to_tick", 0, 1, 0, 0, 6'h00, 4'd0, 1, 6'h00, 0, 1, 2'b01,
                 (k % 2 == 0), 0);
        step("to_inc", 0, 0, 0, 1, 6'h00, 4'd0, 1, 6'h10, 0, 1, 2'b01, 0, 0);
        for (int j = 1; j <= 29; j++)
            step("to_tick2", 0, 1, 0, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b01,
                 (j % 2 == 1), 0);
`ifdef SET_TIMEOUT_EN
        step("to_exit", 0, 1, 0, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b00, 0, 0);
        step("to_m_a", 0, 0, 1, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b01, 1, 0);
        step("to_m_b", 0, 0, 1, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b10, 1, 0);
        for (int j = 1; j <= 29; j++)
            step("to_sm", 0, 1, 0, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b10,
                 (j % 2 == 0), 0);
        step("to_sm_exit", 0, 1, 0, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b00, 0, 1);
        step("to_sm_idle", 0, 0, 0, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b00, 0, 0);
`else
        step("no_to_30", 0, 1, 0, 0, 6'h00, 4'd0, 0, 6'h00, 0, 1, 2'b01, 0, 0);
        for (int j = 31; j <= 34; j++)
            step("no_to_more", 0, 1, 0, 0, 6'h00, 4'd0, 1, 6'h00, 0, 1, 2'b01,
                 (j % 2 == 1), 0);
`endif
        step("tail", 0, 0, 0, 0, 6'h00, 4'd0, 0, 6'h00, 0, 0, 2'b00, 0, 0);
        for (int w = 0; w < 10 && q.size() > 0; w++)
            @(negedge clk_out);
        @(negedge clk_out);
        @(negedge clk_out);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
